// File: rtl/coeff_block_builder.sv
`timescale 1ns/1ps
// Expands decoded (run, size, value) tokens into 64 zigzag-ordered coefficients per 8x8 block,
// with per-component DC prediction and valid/ready handshakes on both sides.
module coeff_block_builder #(
    parameter int NUM_COMP = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_run,
    input  logic [3:0]         in_size,
    input  logic signed [11:0] in_value,
    input  logic [1:0]         in_comp,
    input  logic               pred_clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [11:0] out_coeff,
    output logic [5:0]         out_index,
    output logic               out_last,
    output logic [1:0]         out_comp,
    output logic               err
);

    // state   | meaning
    // S_TOKEN | waiting for a token (DC when pos == 0, AC otherwise)
    // S_RUN   | emitting a zero run, then the pending value if any
    // S_FLUSH | zero fill through index 63 after EOB or overflow
    typedef enum logic [1:0] {S_TOKEN, S_RUN, S_FLUSH} state_t;

    localparam logic [2:0] NUM_COMP_L = 3'(NUM_COMP);

    state_t             state_q, state_d;
    logic [6:0]         pos_q, pos_d;
    logic [3:0]         rem_q, rem_d;
    logic               has_val_q, has_val_d;
    logic signed [11:0] val_q, val_d;
    logic               out_valid_q, out_valid_d;
    logic signed [11:0] out_coeff_q, out_coeff_d;
    logic [5:0]         out_index_q, out_index_d;
    logic               out_last_q, out_last_d;
    logic [1:0]         out_comp_q, out_comp_d;
    logic               err_q, err_d;
    logic signed [11:0] pred_q [NUM_COMP];
    logic signed [11:0] pred_d [NUM_COMP];

    logic               adv, accept, is_end, comp_bad, is_eob_like, ovf, emit;
    logic [1:0]         comp_sel;
    logic signed [11:0] pred_sel, dc_add, dc_coeff, emit_coeff;
    logic [12:0]        dc_sum;
    logic [4:0]         tok_len;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = !reset && (state_q == S_TOKEN) && adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_coeff = out_coeff_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign out_comp  = out_comp_q;
    assign err       = err_q;

    always_comb begin
        is_end   = (pos_q == 7'd63);
        comp_bad = ({1'b0, in_comp} >= NUM_COMP_L);
        comp_sel = comp_bad ? 2'd0 : in_comp;
        pred_sel = '0;
        for (int c = 0; c < NUM_COMP; c++) begin
            if (comp_sel == 2'(c)) pred_sel = pred_q[c];
        end
        // A restart pulse coinciding with a DC token means that token predicts from zero.
        if (pred_clear) pred_sel = '0;
        dc_add = (in_size != 4'd0) ? in_value : 12'sd0;
        dc_sum = {pred_sel[11], pred_sel} + {dc_add[11], dc_add};
        if (dc_sum[12] != dc_sum[11]) dc_coeff = dc_sum[12] ? 12'sh800 : 12'sh7ff;
        else                          dc_coeff = dc_sum[11:0];
        tok_len     = (in_size == 4'd0) ? 5'd16 : ({1'b0, in_run} + 5'd1);
        ovf         = ({2'b00, tok_len} + pos_q) > 7'd64;
        is_eob_like = (in_size == 4'd0) && (in_run != 4'd15);
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        rem_d       = rem_q;
        has_val_d   = has_val_q;
        val_d       = val_q;
        out_valid_d = out_valid_q;
        out_coeff_d = out_coeff_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        out_comp_d  = out_comp_q;
        err_d       = err_q;
        pred_d      = pred_q;
        emit        = 1'b0;
        emit_coeff  = '0;
        if (pred_clear) begin
            for (int c = 0; c < NUM_COMP; c++) pred_d[c] = '0;
        end
        if (adv) begin
            out_valid_d = 1'b0;
            case (state_q)
                S_TOKEN: begin
                    if (accept) begin
                        emit = 1'b1;
                        if (pos_q == 7'd0) begin
                            emit_coeff = dc_coeff;
                            out_comp_d = comp_sel;
                            err_d      = err_q | comp_bad;
                            for (int c = 0; c < NUM_COMP; c++) begin
                                if (comp_sel == 2'(c)) pred_d[c] = dc_coeff;
                            end
                        end else if (is_eob_like || ovf) begin
                            // Size-0 tokens other than EOB/ZRL are malformed; flush like EOB.
                            err_d   = err_q | (is_eob_like ? (in_run != 4'd0) : 1'b1);
                            state_d = is_end ? S_TOKEN : S_FLUSH;
                        end else begin
                            has_val_d = (in_size != 4'd0);
                            val_d     = in_value;
                            rem_d     = 4'(tok_len - 5'd1);
                            if (tok_len == 5'd1) emit_coeff = in_value;
                            else                 state_d    = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    emit  = 1'b1;
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = S_TOKEN;
                        if (has_val_q) emit_coeff = val_q;
                    end
                end
                S_FLUSH: begin
                    emit = 1'b1;
                    if (is_end) state_d = S_TOKEN;
                end
                default: state_d = S_TOKEN;
            endcase
            if (emit) begin
                out_valid_d = 1'b1;
                out_coeff_d = emit_coeff;
                out_index_d = pos_q[5:0];
                out_last_d  = is_end;
                pos_d       = is_end ? 7'd0 : (pos_q + 7'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_TOKEN;
            pos_q       <= '0;
            rem_q       <= '0;
            has_val_q   <= 1'b0;
            val_q       <= '0;
            out_valid_q <= 1'b0;
            out_coeff_q <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            out_comp_q  <= '0;
            err_q       <= 1'b0;
            for (int c = 0; c < NUM_COMP; c++) pred_q[c] <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            rem_q       <= rem_d;
            has_val_q   <= has_val_d;
            val_q       <= val_d;
            out_valid_q <= out_valid_d;
            out_coeff_q <= out_coeff_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            out_comp_q  <= out_comp_d;
            err_q       <= err_d;
            for (int c = 0; c < NUM_COMP; c++) pred_q[c] <= pred_d[c];
        end
    end

endmodule

// File: tb/tb_coeff_block_builder.sv
`timescale 1ns/1ps
// Randomised and directed bench for coeff_block_builder, checked beat by beat against a
// token-level reference model of the block expansion and DC prediction.
module tb_coeff_block_builder;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [3:0]         in_run = '0;
    logic [3:0]         in_size = '0;
    logic signed [11:0] in_value = '0;
    logic [1:0]         in_comp = '0;
    logic               pred_clear = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [11:0] out_coeff;
    logic [5:0]         out_index;
    logic               out_last;
    logic [1:0]         out_comp;
    logic               err;

    coeff_block_builder #(.NUM_COMP(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_run(in_run), .in_size(in_size), .in_value(in_value), .in_comp(in_comp),
        .pred_clear(pred_clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_coeff(out_coeff), .out_index(out_index), .out_last(out_last),
        .out_comp(out_comp), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int coeff;
        int idx;
        bit last;
        int comp;
        bit err;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    int          checks = 0;
    int          failures = 0;
    int          mpos = 0;
    int          mpred[3] = '{0, 0, 0};
    int          mcomp = 0;
    bit          merr = 1'b0;
    int          cap[64];
    int          dc_seen[$];
    int          cyc = 0;
    int          cyc_first = 0;
    int          cyc_last = 0;
    int          beat_count = 0;
    bit          rdy_rand = 1'b0;
    bit          hold = 1'b0;
    logic [21:0] hold_v;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic int sat12(input int s);
        if (s > 2047)  return 2047;
        if (s < -2048) return -2048;
        return s;
    endfunction

    function automatic int last_dc(input int back);
        return dc_seen[dc_seen.size() - 1 - back];
    endfunction

    task automatic push_beat(input int c);
        beat_t b;
        b.coeff = c;
        b.idx   = mpos;
        b.last  = (mpos == 63);
        b.comp  = mcomp;
        b.err   = merr;
        exp_q.push_back(b);
        mpos = (mpos == 63) ? 0 : mpos + 1;
    endtask

    // Reference: what an accepted token contributes to the coefficient stream.
    task automatic model_token(input int run, input int size, input int value, input int comp, input bit clr);
        int c;
        int p;
        int len;
        if (mpos == 0) begin
            c = (comp < 3) ? comp : 0;
            if (comp >= 3) merr = 1'b1;
            p = clr ? 0 : mpred[c];
            if (clr) mpred = '{0, 0, 0};
            mpred[c] = sat12(p + ((size != 0) ? value : 0));
            mcomp = c;
            push_beat(mpred[c]);
        end else begin
            if (clr) mpred = '{0, 0, 0};
            if (size == 0 && run != 15) begin
                if (run != 0) merr = 1'b1;
                do push_beat(0); while (mpos != 0);
            end else begin
                len = (size == 0) ? 16 : run + 1;
                if (mpos + len > 64) begin
                    merr = 1'b1;
                    do push_beat(0); while (mpos != 0);
                end else begin
                    for (int i = 0; i < len - 1; i++) push_beat(0);
                    push_beat((size != 0) ? value : 0);
                end
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mpos  = 0;
        mpred = '{0, 0, 0};
        mcomp = 0;
        merr  = 1'b0;
    endtask

    task automatic send(input int run, input int size, input int value, input int comp, input bit clr);
        int n = 0;
        in_valid   = 1'b1;
        in_run     = 4'(run);
        in_size    = 4'(size);
        in_value   = 12'(value);
        in_comp    = 2'(comp);
        pred_clear = clr;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) model_token(run, size, value, comp, clr);
        else chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        pred_clear = 1'b0;
    endtask

    task automatic dc(input int size, input int value, input int comp, input bit clr);
        send(0, size, value, comp, clr);
    endtask

    task automatic eob();
        send(0, 0, 0, 0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_val();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: every handshake beat against the model, every stall for stability.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) chk("stall_hold", int'({out_valid, out_coeff, out_index, out_last, out_comp}), int'(hold_v));
            hold   = out_valid && !out_ready;
            hold_v = {out_valid, out_coeff, out_index, out_last, out_comp};
            if (out_valid && out_ready) begin
                beat_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", int'(out_index), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", int'({out_coeff, out_index, out_last, out_comp, err}),
                        int'({12'(mon_e.coeff), 6'(mon_e.idx), mon_e.last, 2'(mon_e.comp), mon_e.err}));
                end
                cap[out_index] = int'(out_coeff);
                if (out_index == 6'd0) begin
                    dc_seen.push_back(int'(out_coeff));
                    cyc_first = cyc;
                end
                if (out_last) cyc_last = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0;
        int nz;
        int n;
        int r;
        int comp;

        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({out_valid, out_coeff, out_index, out_last, out_comp, err}), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_release", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // DC chain on component 0
        b0 = beat_count;
        dc(3, 7, 0, 1'b0);
        eob();
        dc(1, -1, 0, 1'b0);
        eob();
        drain();
        chk("dc_chain_beats", beat_count - b0, 128);
        chk("dc_chain_first", last_dc(1), 7);
        chk("dc_chain_second", last_dc(0), 6);
        nz = 0;
        for (int i = 1; i < 64; i++) if (cap[i] != 0) nz++;
        chk("dc_chain_ac_zero", nz, 0);

        // Run expansion, ZRL and EOB at full rate
        dc(0, 123, 0, 1'b0);
        send(2, 3, 5, 0, 1'b0);
        send(15, 0, 0, 0, 1'b0);
        send(0, 2, -3, 0, 1'b0);
        eob();
        drain();
        chk("run_dc", cap[0], 6);
        chk("run_idx3", cap[3], 5);
        chk("run_idx20", cap[20], -3);
        nz = 0;
        for (int i = 1; i < 64; i++) if (i != 3 && i != 20 && cap[i] != 0) nz++;
        chk("run_others_zero", nz, 0);
        chk("run_beat_span", cyc_last - cyc_first, 63);

        // Full block without EOB, then a fresh DC
        dc(0, 0, 0, 1'b0);
        for (int v = 1; v < 64; v++) send(0, 6, v, 0, 1'b0);
        drain();
        nz = 0;
        for (int i = 1; i < 64; i++) if (cap[i] != i) nz++;
        chk("full_values", nz, 0);
        chk("full_span", cyc_last - cyc_first, 63);
        dc(1, 1, 0, 1'b0);
        eob();
        drain();
        chk("full_next_dc", last_dc(0), 7);
        chk("err_clean", int'(err), 0);

        // Saturation both ways
        dc(11, 2047, 0, 1'b1);
        eob();
        dc(10, 1000, 0, 1'b0);
        eob();
        dc(11, -2047, 2, 1'b1);
        eob();
        dc(11, -2047, 2, 1'b0);
        eob();
        drain();
        chk("sat_pos", last_dc(2), 2047);
        chk("sat_neg", last_dc(0), -2048);

        // Randomised blocks with random backpressure and occasional restart pulses
        rdy_rand = 1'b1;
        for (int b = 0; b < 30; b++) begin
            comp = int'($urandom_range(0, 2));
            dc(int'($urandom_range(0, 11)), rand_val(), comp, $urandom_range(0, 5) == 0);
            n = 0;
            while (mpos != 0 && n < 100) begin
                r = int'($urandom_range(0, 99));
                if (r < 8)       eob();
                else if (r < 14) send(15, 0, 0, int'($urandom_range(0, 3)), 1'b0);
                else send((r < 90) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15)),
                          int'($urandom_range(1, 11)), rand_val(), int'($urandom_range(0, 3)),
                          $urandom_range(0, 19) == 0);
                n++;
            end
        end
        drain();

        // Restart pulse coincident with DC, then per-component independence
        dc(3, 4, 1, 1'b1);
        eob();
        dc(2, 3, 0, 1'b0);
        eob();
        dc(2, -2, 1, 1'b0);
        eob();
        dc(1, 1, 0, 1'b0);
        eob();
        dc(2, 2, 2, 1'b0);
        eob();
        drain();
        chk("clear_coincident_dc", last_dc(4), 4);
        chk("pred_comp0_a", last_dc(3), 3);
        chk("pred_comp1", last_dc(2), 2);
        chk("pred_comp0_b", last_dc(1), 4);
        chk("pred_comp2", last_dc(0), 2);
        rdy_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Overflow: value dropped, zero fill, sticky error
        b0 = beat_count;
        dc(0, 0, 2, 1'b0);
        for (int i = 0; i < 60; i++) send(0, 2, 2, 0, 1'b0);
        send(5, 4, 9, 0, 1'b0);
        drain();
        chk("ovf_beats", beat_count - b0, 64);
        chk("ovf_idx60", cap[60], 2);
        chk("ovf_fill", int'(cap[61] != 0) + int'(cap[62] != 0) + int'(cap[63] != 0), 0);
        chk("ovf_err", int'(err), 1);
        dc(1, 1, 1, 1'b0);
        eob();
        drain();
        chk("err_sticky", int'(err), 1);

        // Reset in the middle of a block
        dc(0, 0, 1, 1'b0);
        eob();
        n = 0;
        while (!(out_valid && out_index == 6'd30) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_index30", int'(out_index), 30);
        #2 reset = 1'b1;
        #1;
        chk("midreset_outputs", int'({out_valid, out_coeff, out_index, out_last, out_comp, err}), 0);
        chk("midreset_in_ready", int'(in_ready), 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("in_ready_after_midreset", int'(in_ready), 1);
        dc(2, -3, 2, 1'b0);
        eob();
        drain();
        chk("post_reset_dc", last_dc(0), -3);
        chk("post_reset_err", int'(err), 0);

        // Out-of-range component id
        dc(1, 1, 3, 1'b0);
        eob();
        drain();
        chk("bad_comp_dc", last_dc(0), 1);
        chk("bad_comp_err", int'(err), 1);

        chk("model_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
